// File: rtl/hls_target_mul_pipe.sv
// Pipelined integer multiplier with valid/ready flow control and clock enable.
// Optional HLS_MUL_PIPE_SAT_EN: saturate narrow results and add an ovf output.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   ce           clock enable; low freezes every register
//   in_valid/in_ready, din0, din1   operand pair handshake
//   out_valid/out_ready, dout       result handshake
//   ovf          (HLS_MUL_PIPE_SAT_EN only) result was clamped
module hls_target_mul_pipe #(
    parameter int DIN0_WIDTH = 12,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 20,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout
`ifdef HLS_MUL_PIPE_SAT_EN
    ,
    output logic                  ovf
`endif
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;

    logic [P-1:0]          prod;
    logic [DOUT_WIDTH-1:0] res;
    logic                  advance;
`ifdef HLS_MUL_PIPE_SAT_EN
    logic                  res_ovf;
`endif

    generate
        if (SIGNED != 0) begin : g_smul
            logic signed [P-1:0] sa;
            logic signed [P-1:0] sb;
            assign sa   = P'($signed(din0));
            assign sb   = P'($signed(din1));
            assign prod = sa * sb;
        end else begin : g_umul
            assign prod = P'(din0) * P'(din1);
        end
    endgenerate

    generate
        if (DOUT_WIDTH > P) begin : g_ext
            logic ext;
            assign ext = (SIGNED != 0) & prod[P-1];
            assign res = {{(DOUT_WIDTH - P){ext}}, prod};
`ifdef HLS_MUL_PIPE_SAT_EN
            assign res_ovf = 1'b0;
`endif
        end else if (DOUT_WIDTH == P) begin : g_same
            assign res = prod;
`ifdef HLS_MUL_PIPE_SAT_EN
            assign res_ovf = 1'b0;
`endif
        end else begin : g_narrow
`ifdef HLS_MUL_PIPE_SAT_EN
            if (SIGNED != 0) begin : g_ssat
                // In range only if all bits from the result sign upward agree.
                logic [P-DOUT_WIDTH:0] top;
                logic [DOUT_WIDTH-1:0] smin;
                assign top     = prod[P-1:DOUT_WIDTH-1];
                assign smin    = DOUT_WIDTH'(1) << (DOUT_WIDTH - 1);
                assign res_ovf = ~(&top | ~|top);
                assign res     = !res_ovf ? prod[DOUT_WIDTH-1:0] :
                                 prod[P-1] ? smin : ~smin;
            end else begin : g_usat
                assign res_ovf = |prod[P-1:DOUT_WIDTH];
                assign res     = res_ovf ? '1 : prod[DOUT_WIDTH-1:0];
            end
`else
            assign res = DOUT_WIDTH'(prod);
`endif
        end
    endgenerate

    logic [NUM_STAGE-1:0]  vld_q;
    logic [DOUT_WIDTH-1:0] dat_q [NUM_STAGE];
`ifdef HLS_MUL_PIPE_SAT_EN
    logic [NUM_STAGE-1:0]  ovf_q;
`endif

    assign out_valid = vld_q[NUM_STAGE-1];
    assign dout      = dat_q[NUM_STAGE-1];
    assign advance   = ce & ~reset & (~out_valid | out_ready);
    assign in_ready  = advance;
`ifdef HLS_MUL_PIPE_SAT_EN
    assign ovf       = ovf_q[NUM_STAGE-1];
`endif

    // Data only moves behind a valid bit, so bubbles never overwrite
    // a stage and dout keeps its last result while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                dat_q[i] <= '0;
            end
`ifdef HLS_MUL_PIPE_SAT_EN
            ovf_q <= '0;
`endif
        end else if (advance) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= res;
`ifdef HLS_MUL_PIPE_SAT_EN
                ovf_q[0] <= res_ovf;
`endif
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
`ifdef HLS_MUL_PIPE_SAT_EN
                    ovf_q[i] <= ovf_q[i-1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hls_target_mul_pipe.sv
// Directed bench for hls_target_mul_pipe: default, signed and 16-bit result
// instances, with a queue scoreboard on the default instance.
module tb_hls_target_mul_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        out_ready;

    logic        in_valid;
    logic        in_ready;
    logic [11:0] din0;
    logic [7:0]  din1;
    logic        out_valid;
    logic [19:0] dout;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_din0;
    logic [7:0]  s_din1;
    logic        s_out_valid;
    logic [19:0] s_dout;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [11:0] w_din0;
    logic [7:0]  w_din1;
    logic        w_out_valid;
    logic [15:0] w_dout;

`ifdef HLS_MUL_PIPE_SAT_EN
    logic        ovf;
    logic        s_ovf;
    logic        w_ovf;
`endif

    always #5 clk = ~clk;

    hls_target_mul_pipe dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout)
`ifdef HLS_MUL_PIPE_SAT_EN
        , .ovf(ovf)
`endif
    );

    hls_target_mul_pipe #(.SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din0(s_din0), .din1(s_din1),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .dout(s_dout)
`ifdef HLS_MUL_PIPE_SAT_EN
        , .ovf(s_ovf)
`endif
    );

    hls_target_mul_pipe #(.DOUT_WIDTH(16)) dut_w (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .din0(w_din0), .din1(w_din1),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .dout(w_dout)
`ifdef HLS_MUL_PIPE_SAT_EN
        , .ovf(w_ovf)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int last_out_cyc = 0;
    int ce_a = 0, ce_b = 0, or_a = 0, or_b = 0;
    logic [19:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model(input logic [11:0] a,
                                          input logic [7:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[19:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard plus hold checks on the default instance.
    logic        mon_en = 1'b0;
    logic        p_adv, p_rst, p_ov;
    logic [19:0] p_dout;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!p_rst && !p_adv) begin
                check("hold_valid", 32'(out_valid), 32'(p_ov));
                check("hold_dout", 32'(dout), 32'(p_dout));
            end
            if (!ce || (out_valid && !out_ready))
                check("stall_in_ready", 32'(in_ready), 32'd0);
            if (reset) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && ce) begin
                    check("spurious_out", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0)
                        check("sb_dout", 32'(dout), 32'(sb.pop_front()));
                    n_out++;
                    last_out_cyc = cyc;
                end
                if (in_valid && in_ready)
                    sb.push_back(model(din0, din1));
            end
        end
        p_adv  = ce & ~reset & (~out_valid | out_ready);
        p_rst  = reset;
        p_ov   = out_valid;
        p_dout = dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(output bit acc, output int stamp);
        ce        = !(cyc >= ce_a && cyc < ce_b);
        out_ready = !(cyc >= or_a && cyc < or_b);
        #1;
        acc   = in_ready;
        stamp = cyc;
        tick();
    endtask

    task automatic run_stream(input int ce_len, input int or_len,
                              output int span);
        int base, first, guard, st;
        bit acc;
        base  = cyc;
        first = 0;
        n_out = 0;
        ce_a = base + 4; ce_b = base + 4 + ce_len;
        or_a = base + 5; or_b = base + 5 + or_len;
        for (int k = 1; k <= 10; k++) begin
            din0 = 12'(k);
            din1 = 8'(k + 1);
            in_valid = 1'b1;
            guard = 0;
            do begin
                drive_cycle(acc, st);
                guard++;
            end while (!acc && guard < 20);
            check("accept_timeout", 32'(acc), 32'd1);
            if (k == 1) first = st;
        end
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            drive_cycle(acc, st);
            guard++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        check("stream_count", 32'(n_out), 32'd10);
        span = last_out_cyc - first;
        ce = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        int span;
        reset = 1'b1; ce = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; din0 = '0; din1 = '0;
        s_in_valid = 1'b0; s_din0 = '0; s_din1 = '0;
        w_in_valid = 1'b0; w_din0 = '0; w_din1 = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_s_dout", 32'(s_dout), 32'd0);
        mon_en = 1'b1;
        reset = 1'b0;
        tick();

        // Single pulse, latency and one-cycle valid
        din0 = 12'd4095; din1 = 8'd255; in_valid = 1'b1;
        check("pulse_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("lat_n0", 32'(out_valid), 32'd0);
        tick();
        check("lat_n1", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_dout", 32'(dout), 32'hFEF01);
        tick();
        check("pulse_one_cycle", 32'(out_valid), 32'd0);
        check("idle_dout_hold", 32'(dout), 32'hFEF01);

        // Signed instance and 16-bit result instance
        s_din0 = 12'hFFF; s_din1 = 8'h02; s_in_valid = 1'b1;
        w_din0 = 12'd4095; w_din1 = 8'd255; w_in_valid = 1'b1;
        tick();
        s_din0 = 12'h800; s_din1 = 8'h80;
        w_din0 = 12'd100; w_din1 = 8'd200;
        tick();
        s_in_valid = 1'b0; w_in_valid = 1'b0;
        tick();
        check("s_neg_valid", 32'(s_out_valid), 32'd1);
        check("s_neg_dout", 32'(s_dout), 32'hFFFFE);
        check("w_big_valid", 32'(w_out_valid), 32'd1);
`ifdef HLS_MUL_PIPE_SAT_EN
        check("w_big_dout", 32'(w_dout), 32'hFFFF);
        check("w_big_ovf", 32'(w_ovf), 32'd1);
`else
        check("w_big_dout", 32'(w_dout), 32'hEF01);
`endif
        tick();
        check("s_min_dout", 32'(s_dout), 32'h40000);
        check("w_fit_dout", 32'(w_dout), 32'h4E20);
`ifdef HLS_MUL_PIPE_SAT_EN
        check("w_fit_ovf", 32'(w_ovf), 32'd0);
`endif
        tick();

        // Streams: unstalled, out_ready stall, ce stall
        run_stream(0, 0, span);
        check("span_unstalled", 32'(span), 32'd12);
        run_stream(0, 4, span);
        run_stream(5, 0, span);
        check("span_ce_stall", 32'(span), 32'd17);
        tick();

        // Reset with two results in flight
        din0 = 12'd7; din1 = 8'd9; in_valid = 1'b1;
        tick();
        din0 = 12'd11; din1 = 8'd13;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale", 32'(out_valid), 32'd0);
        end
        din0 = 12'd3; din1 = 8'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_n1", 32'(out_valid), 32'd0);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_dout", 32'(dout), 32'd15);
        tick();
        tick();
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
